// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide sequencer.
//   muldiv_state_t : sequencer states (IDLE, MULT, DIV, FIX, DONE)
//   muldiv_op_t    : which operation is in flight (OP_MULT, OP_DIV)
//   MULDIV_WIDTH   : default operand / HI / LO width
//   CNT_W          : iteration counter width for the default width
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int CNT_W        = $clog2(MULDIV_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } muldiv_state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
//   value  in  N  value to condition
//   negate in  1  1 = return -value, 0 = pass through
//   result out N  conditioned value
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int N = 2 * MULDIV_WIDTH
) (
    input  logic [N-1:0] value,
    input  logic         negate,
    output logic [N-1:0] result
);

    assign result = negate ? (~value + N'(1)) : value;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO sequencer (shift-add multiply, restoring divide).
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous active-low reset
//   a           in   WIDTH  multiplicand / dividend
//   b           in   WIDTH  multiplier / divisor
//   start_mult  in   1      one-cycle signed multiply request
//   start_div   in   1      one-cycle signed divide request
//   wr_hi/wr_lo in   1      direct HI / LO write (mthi / mtlo)
//   wdata       in   WIDTH  data for direct writes
//   unsigned_op in   1      only with MULDIV_UNSIGNED_EN: treat operands as unsigned
//   hi, lo      out  WIDTH  HI / LO registers
//   busy        out  1      operation in progress (state != IDLE)
//   done        out  1      one-cycle completion pulse
//   div_zero    out  1      accompanies done when the divisor was zero
// Optional feature macro: MULDIV_UNSIGNED_EN (adds unsigned_op; multu/divu).
//
// Handshake: start_mult/start_div and wr_hi/wr_lo are sampled only while
// busy=0; a start raises busy on the next cycle and the result is valid in
// hi/lo from the done cycle on. Requests made while busy are dropped, not queued.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t      state, state_nxt;
    muldiv_op_t         op_q;
    logic               neg_res;   // result sign differs (product / quotient)
    logic               neg_rem;   // remainder takes dividend sign
    logic               dz_q;      // current op took the zero-divisor path
    logic [2*WIDTH-1:0] acc;       // mult: {partial sum, multiplier}; div: {remainder, dividend}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [CW-1:0]      cnt;

    logic               signed_op;
`ifdef MULDIV_UNSIGNED_EN
    assign signed_op = ~unsigned_op;
`else
    assign signed_op = 1'b1;
`endif

    logic sign_a, sign_b;
    assign sign_a = signed_op & a[WIDTH-1];
    assign sign_b = signed_op & b[WIDTH-1];

    logic [WIDTH-1:0] mag_a, mag_b;
    muldiv_signfix #(.N(WIDTH)) u_abs_a (.value(a), .negate(sign_a), .result(mag_a));
    muldiv_signfix #(.N(WIDTH)) u_abs_b (.value(b), .negate(sign_b), .result(mag_b));

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    muldiv_signfix #(.N(2*WIDTH)) u_fix_prod (.value(acc), .negate(neg_res), .result(prod_fix));
    muldiv_signfix #(.N(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .negate(neg_res), .result(quo_fix));
    muldiv_signfix #(.N(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .negate(neg_rem), .result(rem_fix));

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole register right, keeping the carry.
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_nxt;
    assign mult_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mult_nxt = {mult_sum, acc[WIDTH-1:1]};

    // Restoring step: trial-subtract divisor from {rem, next dividend bit}.
    // Bit WIDTH of the trial is set exactly when the subtraction went negative.
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_nxt;
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    assign div_nxt   = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    logic last_step;
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        div_zero  = 1'b0;
        case (state)
            IDLE: begin
                if (start_mult)     state_nxt = MULT;
                else if (start_div) state_nxt = (b == '0) ? DONE : DIV;
            end
            MULT, DIV: begin
                if (last_step) state_nxt = FIX;
            end
            FIX:  state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                div_zero  = dz_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi      <= '0;
            lo      <= '0;
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            op_q    <= OP_MULT;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Direct writes and a start in the same cycle both take effect.
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    cnt <= '0;
                    if (start_mult) begin
                        op_q    <= OP_MULT;
                        acc     <= {{WIDTH{1'b0}}, mag_b};
                        opnd    <= mag_a;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        dz_q    <= 1'b0;
                    end else if (start_div) begin
                        op_q    <= OP_DIV;
                        acc     <= {{WIDTH{1'b0}}, mag_a};
                        opnd    <= mag_b;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        dz_q    <= (b == '0);
                    end
                end
                MULT: begin
                    acc <= mult_nxt;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (op_q == OP_MULT) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed, table-driven bench for muldiv_ctrl (WIDTH=32).
module tb_muldiv_ctrl;

    localparam int W       = 32;
    localparam int LAT     = W + 2;
    localparam int NVEC    = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  a, b, wdata;
    logic          start_mult, start_div, wr_hi, wr_lo;
    logic          unsigned_op;
    logic [W-1:0]  hi, lo;
    logic          busy, done, div_zero;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        string        name;
        logic         is_div;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
    } vec_t;

    vec_t vecs[NVEC];

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .start_mult (start_mult),
        .start_div  (start_div),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .wdata      (wdata),
`ifdef MULDIV_UNSIGNED_EN
        .unsigned_op(unsigned_op),
`endif
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a request at the falling edge; returns #1 after the sampling edge (cycle 1).
    task automatic start_op(input logic sm, input logic sd, input logic uns,
                            input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic whi, input logic [W-1:0] wv);
        @(negedge clk);
        a = va; b = vb; start_mult = sm; start_div = sd; unsigned_op = uns;
        wr_hi = whi; wdata = wv;
        @(posedge clk); #1;
        start_mult = 1'b0; start_div = 1'b0; wr_hi = 1'b0; unsigned_op = 1'b0;
    endtask

    // Walk cycles from cycle 1 until done (bounded), then check latency and results.
    task automatic finish_op(input string name, input int exp_lat,
                             input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        int lat      = 0;
        int busy_bad = 0;
        for (int n = 1; n <= 100; n++) begin
            if (!busy) busy_bad++;
            if (done) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy"}, busy_bad, 0);
        check({name, " hi"}, hi, ehi);
        check({name, " lo"}, lo, elo);
        check({name, " div_zero"}, div_zero, edz);
        @(posedge clk); #1;
        check({name, " idle after"}, {busy, done, div_zero}, 3'b000);
    endtask

    initial begin
        vecs[0]  = '{"mult_7_m3",     1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{"mult_min_min",  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2]  = '{"mult_m1_m1",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3]  = '{"mult_max_max",  1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[4]  = '{"mult_ffff",     1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};
        vecs[5]  = '{"mult_min_2",    1'b0, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6]  = '{"div_m7_2",      1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7]  = '{"div_100_7",     1'b1, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[8]  = '{"div_7_m2",      1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{"div_m7_m2",     1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[10] = '{"div_min_m1",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[11] = '{"div_3_10",      1'b1, 32'd3,         32'd10,        32'd3,         32'd0};
        vecs[12] = '{"mult_zero",     1'b0, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};

        reset = 1'b0; a = '0; b = '0; wdata = '0;
        start_mult = 1'b0; start_div = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; unsigned_op = 1'b0;
        #1;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // table-driven operations
        for (int i = 0; i < NVEC; i++) begin
            start_op(!vecs[i].is_div, vecs[i].is_div, 1'b0, vecs[i].va, vecs[i].vb, 1'b0, '0);
            finish_op(vecs[i].name, LAT, vecs[i].ehi, vecs[i].elo, 1'b0);
        end

        // joint direct write, then separate preload of HI/LO
        @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h55;
        @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr both hi", hi, 32'h55);
        check("wr both lo", lo, 32'h55);
        @(negedge clk); wr_hi = 1'b1; wdata = 32'h11;
        @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h22;
        @(negedge clk); wr_lo = 1'b0;

        // zero divisor: one-cycle done with div_zero, HI/LO untouched
        start_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, '0);
        finish_op("div_by_zero", 1, 32'h11, 32'h22, 1'b1);

        // direct write accepted together with a start; FIX later overwrites HI
        start_op(1'b1, 1'b0, 1'b0, 32'd2, 32'd3, 1'b1, 32'hAB);
        check("wr_with_start hi", hi, 32'hAB);
        finish_op("wr_with_start", LAT, 32'd0, 32'd6, 1'b0);

        // simultaneous starts: multiply wins
        start_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd3, 1'b0, '0);
        finish_op("both_starts", LAT, 32'd0, 32'd18, 1'b0);

        // ignored requests while busy, then reset at iteration 10
        start_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd5, 1'b0, '0);
        @(negedge clk); start_div = 1'b1; b = 32'd1; wr_lo = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1; start_div = 1'b0; wr_lo = 1'b0;
        check("busy wr_lo ignored", lo, 32'd18);
        check("busy still busy", busy, 1'b1);
        repeat (8) @(posedge clk);
        begin
            int dc;
            dc = done_cnt;
            @(negedge clk) reset = 1'b0;
            #1;
            check("abort busy", busy, 1'b0);
            check("abort hi", hi, 0);
            check("abort lo", lo, 0);
            repeat (3) @(posedge clk);
            @(negedge clk) reset = 1'b1;
            repeat (40) @(posedge clk);
            #1;
            check("abort no done", done_cnt - dc, 0);
            check("abort stays idle", busy, 1'b0);
        end

        // recovery after abort
        start_op(1'b1, 1'b0, 1'b0, 32'd6, 32'd7, 1'b0, '0);
        finish_op("after_abort", LAT, 32'd0, 32'd42, 1'b0);

`ifdef MULDIV_UNSIGNED_EN
        start_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, '0);
        finish_op("divu", LAT, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
        start_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, '0);
        finish_op("multu", LAT, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
